// File: rtl/wbram_dbuf_scheduler.sv
// Double-buffer slot scheduler for the weight BRAM: grants slots to the writer,
// publishes the write pointer to the read chain and sequences an N-layer job.
module wbram_dbuf_scheduler #(
  parameter int unsigned MAX_NUM_LAYERS = 4,
  parameter int unsigned LW             = $clog2(MAX_NUM_LAYERS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [LW-1:0] cfg_num_layers,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          wr_grant_valid,
  input  logic          wr_grant_ready,
  output logic          wr_grant_slot,
  output logic [LW-1:0] wr_grant_layer,
  input  logic          wr_done,
  output logic [1:0]    wr_pointer_data,
  output logic          wr_pointer_valid,
  input  logic          wr_pointer_ready,
  input  logic          rd_release,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e        state_q, state_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] n_layers_q, n_layers_d, granted_q, granted_d;
  logic [LW-1:0] loaded_q, loaded_d, released_q, released_d;
  logic          grant_out_q, grant_out_d;
  logic          gvalid_q, gvalid_d, gslot_q, gslot_d;
  logic [LW-1:0] glayer_q, glayer_d;
  logic [1:0]    pdata_q, pdata_d;
  logic          pvalid_q, pvalid_d;
  logic          err_q, err_d, done_q;

  logic          in_run, wr_done_ok, rel_ok, offer;
  logic [LW-1:0] released_inc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);

  assign in_run       = (state_q == RUN);
  assign wr_done_ok   = wr_done && grant_out_q && in_run;
  assign rel_ok       = rd_release && !empty && in_run;
  assign offer        = in_run && !full && !grant_out_q && !gvalid_q && (granted_q < n_layers_q);
  // Includes the current-cycle release so the last release finishes the job immediately.
  assign released_inc = released_q + (rel_ok ? LW'(1) : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == FINISH);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid) state_d = (cfg_num_layers != '0) ? RUN : FINISH;
      RUN:     if (released_inc == n_layers_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    n_layers_d  = n_layers_q;
    granted_d   = granted_q;
    loaded_d    = loaded_q;
    released_d  = released_inc;
    grant_out_d = grant_out_q;
    gvalid_d    = gvalid_q;
    gslot_d     = gslot_q;
    glayer_d    = glayer_q;
    pdata_d     = pdata_q;
    pvalid_d    = pvalid_q;
    err_d       = err_q;

    if (pvalid_q && wr_pointer_ready) pvalid_d = 1'b0;

    if ((state_q == IDLE) && cfg_valid) begin
      n_layers_d  = cfg_num_layers;
      granted_d   = '0;
      loaded_d    = '0;
      released_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      grant_out_d = 1'b0;
      gvalid_d    = 1'b0;
    end

    if (gvalid_q && wr_grant_ready) begin
      gvalid_d    = 1'b0;
      granted_d   = granted_q + LW'(1);
      grant_out_d = 1'b1;
    end else if (offer) begin
      gvalid_d = 1'b1;
      gslot_d  = wr_ptr_q[0];
      glayer_d = granted_q;
    end

    // A new pointer overrides any pending one; a same-cycle ready retires only the old value.
    if (wr_done_ok) begin
      wr_ptr_d    = wr_ptr_q + 2'd1;
      loaded_d    = loaded_q + LW'(1);
      grant_out_d = 1'b0;
      pdata_d     = wr_ptr_q + 2'd1;
      pvalid_d    = 1'b1;
    end

    if (rel_ok) rd_ptr_d = rd_ptr_q + 2'd1;

    if ((wr_done && !wr_done_ok) || (rd_release && !rel_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      n_layers_q  <= '0;
      granted_q   <= '0;
      loaded_q    <= '0;
      released_q  <= '0;
      grant_out_q <= 1'b0;
      gvalid_q    <= 1'b0;
      gslot_q     <= 1'b0;
      glayer_q    <= '0;
      pdata_q     <= '0;
      pvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      n_layers_q  <= n_layers_d;
      granted_q   <= granted_d;
      loaded_q    <= loaded_d;
      released_q  <= released_d;
      grant_out_q <= grant_out_d;
      gvalid_q    <= gvalid_d;
      gslot_q     <= gslot_d;
      glayer_q    <= glayer_d;
      pdata_q     <= pdata_d;
      pvalid_q    <= pvalid_d;
      err_q       <= err_d;
    end
  end

  assign wr_grant_valid   = gvalid_q;
  assign wr_grant_slot    = gslot_q;
  assign wr_grant_layer   = glayer_q;
  assign wr_pointer_data  = pdata_q;
  assign wr_pointer_valid = pvalid_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_wbram_dbuf_scheduler.sv
// Directed bench for wbram_dbuf_scheduler: job sequencing, back-pressure,
// pointer coalescing, simultaneous events, protocol errors and mid-job reset.
module tb_wbram_dbuf_scheduler;

  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_num_layers;
  logic          cfg_valid, cfg_ready;
  logic          wr_grant_valid, wr_grant_ready, wr_grant_slot;
  logic [LW-1:0] wr_grant_layer;
  logic          wr_done;
  logic [1:0]    wr_pointer_data;
  logic          wr_pointer_valid, wr_pointer_ready;
  logic          rd_release, full, empty, busy, done, err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  wbram_dbuf_scheduler #(.MAX_NUM_LAYERS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_num_layers(cfg_num_layers), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .wr_grant_valid(wr_grant_valid), .wr_grant_ready(wr_grant_ready),
    .wr_grant_slot(wr_grant_slot), .wr_grant_layer(wr_grant_layer),
    .wr_done(wr_done),
    .wr_pointer_data(wr_pointer_data), .wr_pointer_valid(wr_pointer_valid),
    .wr_pointer_ready(wr_pointer_ready),
    .rd_release(rd_release), .full(full), .empty(empty),
    .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gv"},    wr_grant_valid, 0);
    chk({tag, "_pv"},    wr_pointer_valid, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_slot"},  wr_grant_slot, 0);
    chk({tag, "_layer"}, wr_grant_layer, 0);
    chk({tag, "_pdata"}, wr_pointer_data, 0);
    chk({tag, "_crdy"},  cfg_ready, 1);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  task automatic start_job(input logic [LW-1:0] n);
    cfg_num_layers = n;
    cfg_valid      = 1'b1;
    step();
    cfg_valid      = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int unsigned n = 0;
    while (!wr_grant_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_gv_wait"}, wr_grant_valid, 1);
  endtask

  task automatic fill(input string tag, input logic slot, input logic [LW-1:0] layer);
    wait_grant(tag);
    chk({tag, "_slot"}, wr_grant_slot, slot);
    chk({tag, "_layer"}, wr_grant_layer, layer);
    wr_grant_ready = 1'b1;
    step();
    wr_grant_ready = 1'b0;
    chk({tag, "_gv_drop"}, wr_grant_valid, 0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  task automatic release_pulse();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_num_layers = '0; cfg_valid = 1'b0; wr_grant_ready = 1'b0;
    wr_done = 1'b0; wr_pointer_ready = 1'b1; rd_release = 1'b0;
    step(); step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // Two-layer job, in-order fill and release
    start_job(3'd2);
    chk("s1_busy", busy, 1);
    chk("s1_crdy", cfg_ready, 0);
    chk("s1_gv_early", wr_grant_valid, 0);
    step();
    chk("s1_gv_lat", wr_grant_valid, 1);
    fill("s1a", 1'b0, 3'd0);
    chk("s1a_pv", wr_pointer_valid, 1);
    chk("s1a_pd", wr_pointer_data, 1);
    chk("s1a_full", full, 0);
    chk("s1a_empty", empty, 0);
    fill("s1b", 1'b1, 3'd1);
    chk("s1b_pd", wr_pointer_data, 2);
    chk("s1b_full", full, 1);
    chk("s1b_empty", empty, 0);
    release_pulse();
    chk("s1r1_full", full, 0);
    chk("s1r1_empty", empty, 0);
    chk("s1r1_done", done, 0);
    release_pulse();
    chk("s1r2_done", done, 1);
    chk("s1r2_empty", empty, 1);
    step();
    chk("s1_idle_done", done, 0);
    chk("s1_idle_crdy", cfg_ready, 1);
    chk("s1_idle_busy", busy, 0);

    // Four layers, reader stalls, pointer wrap
    start_job(3'd4);
    fill("s2a", 1'b0, 3'd0);
    fill("s2b", 1'b1, 3'd1);
    chk("s2_full", full, 1);
    step(); step();
    chk("s2_nogrant", wr_grant_valid, 0);
    release_pulse();
    chk("s2r_full", full, 0);
    chk("s2r_gv0", wr_grant_valid, 0);
    step();
    chk("s2r_gv1", wr_grant_valid, 1);
    fill("s2c", 1'b0, 3'd2);
    chk("s2c_pd", wr_pointer_data, 3);
    chk("s2c_full", full, 1);
    release_pulse();
    fill("s2d", 1'b1, 3'd3);
    chk("s2d_pd_wrap", wr_pointer_data, 0);
    chk("s2d_pv", wr_pointer_valid, 1);
    chk("s2d_full", full, 1);
    release_pulse();
    chk("s2_done_early", done, 0);
    release_pulse();
    chk("s2_done", done, 1);
    step();

    // Pointer back-pressure and coalescing
    wr_pointer_ready = 1'b0;
    start_job(3'd2);
    fill("s3a", 1'b0, 3'd0);
    chk("s3a_pv", wr_pointer_valid, 1);
    chk("s3a_pd", wr_pointer_data, 1);
    fill("s3b", 1'b1, 3'd1);
    chk("s3b_pv", wr_pointer_valid, 1);
    chk("s3b_pd", wr_pointer_data, 2);
    step();
    chk("s3_hold_pv", wr_pointer_valid, 1);
    chk("s3_hold_pd", wr_pointer_data, 2);
    wr_pointer_ready = 1'b1;
    step();
    chk("s3_xfer_pv", wr_pointer_valid, 0);
    release_pulse();
    release_pulse();
    chk("s3_done", done, 1);
    step();

    // Simultaneous wr_done and rd_release with one slot loaded
    start_job(3'd2);
    fill("s4a", 1'b0, 3'd0);
    wait_grant("s4b");
    wr_grant_ready = 1'b1;
    step();
    wr_grant_ready = 1'b0;
    wr_done = 1'b1; rd_release = 1'b1;
    step();
    wr_done = 1'b0; rd_release = 1'b0;
    chk("s4_full", full, 0);
    chk("s4_empty", empty, 0);
    chk("s4_err", err, 0);
    chk("s4_pd", wr_pointer_data, 2);
    release_pulse();
    chk("s4_done", done, 1);
    chk("s4_empty_end", empty, 1);
    step();

    // Zero-layer job, then wr_done without a grant
    start_job(3'd0);
    chk("s5_zero_done", done, 1);
    chk("s5_zero_gv", wr_grant_valid, 0);
    step();
    chk("s5_zero_idle", done, 0);
    chk("s5_zero_crdy", cfg_ready, 1);
    start_job(3'd1);
    chk("s5_err0", err, 0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("s5_wd_err", err, 1);
    chk("s5_wd_empty", empty, 1);
    chk("s5_wd_pv", wr_pointer_valid, 0);
    step();
    chk("s5_sticky", err, 1);

    // Reset clears err; release on empty; reset with a grant pending
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("s6_err_clr", err, 0);
    step();
    start_job(3'd1);
    release_pulse();
    chk("s6_rel_err", err, 1);
    chk("s6_rel_empty", empty, 1);
    chk("s6_gv_pend", wr_grant_valid, 1);
    rst_n = 1'b0;
    step();
    chk_reset("s6_rst");
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
